// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector:
// FSM state encoding exported on the debug port.
package seq_det_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_ARMED = 2'b10,
    ST_HIT   = 2'b11
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. A clear that coincides
// with an increment leaves the counter at one, so that event is not lost.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = inc ? CNT_W'(1) : '0;
    end else if (inc && (count != CNT_MAX)) begin
      count_nxt = count + 1'b1;
    end
  end

  // sat is registered alongside count so both change on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= count_nxt;
      sat   <= (count_nxt == CNT_MAX);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with selectable overlap and a
// saturating match counter; the FSM state is exported for debug.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 3,
  parameter int                 CNT_W   = 8,
  parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(3'b101)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic               din,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               pat_load,
  input  logic               overlap_en,
  input  logic               count_clr,
  output logic               match,
  output logic [CNT_W-1:0]   count,
  output logic               sat,
  output logic [STATE_W-1:0] state
);

  localparam int               FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  // The oldest history bit is shifted out on the very edge it would be
  // compared, so only PAT_LEN-1 bits need to be stored.
  logic [PAT_LEN-2:0] hist;
  logic [PAT_LEN-1:0] hist_nxt;
  logic [PAT_LEN-1:0] pat_reg;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_nxt;
  state_t             st;
  logic               accept;
  logic               hit;

  assign accept   = din_valid & ~pat_load;
  assign hist_nxt = {hist, din};
  assign fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
  assign hit      = accept && (fill_nxt == FILL_FULL) && (hist_nxt == pat_reg);
  assign state    = st;

  function automatic state_t state_of_fill(input logic [FILL_W-1:0] f);
    if (f == '0)             return ST_IDLE;
    else if (f == FILL_FULL) return ST_ARMED;
    else                     return ST_FILL;
  endfunction

  // Non-overlap mode empties the fill on a hit so the next match needs
  // PAT_LEN fresh bits; overlap mode keeps it full to reuse the suffix.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist    <= '0;
      pat_reg <= PAT_RST;
      fill    <= '0;
      st      <= ST_IDLE;
      match   <= 1'b0;
    end else if (pat_load) begin
      hist    <= '0;
      pat_reg <= pattern;
      fill    <= '0;
      st      <= ST_IDLE;
      match   <= 1'b0;
    end else if (accept) begin
      hist <= hist_nxt[PAT_LEN-2:0];
      if (hit) begin
        st    <= ST_HIT;
        match <= 1'b1;
        fill  <= overlap_en ? fill_nxt : '0;
      end else begin
        st    <= state_of_fill(fill_nxt);
        match <= 1'b0;
        fill  <= fill_nxt;
      end
    end else begin
      match <= 1'b0;
      if (st == ST_HIT) begin
        st <= state_of_fill(fill);
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (count_clr),
    .count (count),
    .sat   (sat)
  );

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Programmable serial pattern detector, parametrised successor to the fixed 3-bit sequence detector. It detects a runtime-loadable PAT_LEN-bit pattern on a qualified serial input. Overlapping or non-overlapping detection is selectable, and it keeps a saturating match counter. It sits on serial bit streams (framing/sync-word search) and exposes its FSM state for debug.

Parameters:
PAT_LEN, 3, pattern length in bits; legal range 2..16.
CNT_W, 8, width of match counter.
PAT_RST, 'b101, pattern register value after reset (PAT_LEN bits).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset.
din_valid  input  1  din is sampled only when high.
din  input  1  serial data bit.
pattern  input  PAT_LEN  new pattern; the first-received bit is the MSB.
pat_load  input  1  capture pattern into pat_reg; flush history.
overlap_en  input  1  1 = overlapping matches allowed; sampled every accepted bit.
count_clr  input  1  synchronous clear of count.
match  output  1  one-cycle pulse per detected pattern.
count  output  CNT_W  number of matches, saturating.
sat  output  1  high while count equals all-ones.
state  output  2  FSM state (encoding below).

Behaviour:
- Reset (rst=0, async): state=IDLE, fill=0, history=0, pat_reg=PAT_RST, match=0, count=0, sat=0.
- Accepted bit: a rising edge with din_valid=1 and pat_load=0. Then hist <= {hist[PAT_LEN-2:0], din}, fill <= min(fill+1, PAT_LEN).
- din_valid=0: history, fill and state hold. Gaps never break a partial match.
- Detection: on an accepted bit where the post-shift fill==PAT_LEN and the post-shift hist==pat_reg, enter HIT. match is high exactly while state==HIT, i.e. the cycle after the completing edge. Latency is 1 clock.
- Non-overlap mode (overlap_en=0 at the completing bit): fill <= 0 on entering HIT. The next match needs PAT_LEN fresh bits.
- Overlap mode: fill stays PAT_LEN, so the suffix of a match can start the next one.
- FSM states:
  - IDLE=2'b00: fill==0. An accepted bit moves to FILL.
  - FILL=2'b01: 0<fill<PAT_LEN. The bit that completes fill goes to HIT if it matches, otherwise to ARMED.
  - ARMED=2'b10: fill==PAT_LEN, no match. A matching bit goes to HIT; other accepted bits stay in ARMED.
  - HIT=2'b11: lasts exactly one cycle (the match pulse).
    - With an accepted bit that cycle: HIT again on a further match (overlap only), else ARMED (overlap) or FILL (non-overlap, fill=1).
    - With no bit: ARMED (overlap) or IDLE (non-overlap).
- pat_load: pat_reg <= pattern, hist <= 0, fill <= 0, state <= IDLE, match <= 0. count is retained. If din_valid is high in the same cycle, load wins and that din bit is discarded.
- Counter:
  - Increments on every entry to HIT; holds at 2^CNT_W-1.
  - sat = (count == all-ones), registered with count.
  - If count_clr and a HIT entry fall in the same cycle, count <= 1. count_clr alone gives count <= 0.
- Reset mid-stream: everything returns to reset values immediately. A pending match is never emitted.

Decomposition:
- Shared package seq_det_pkg holds the state encodings ST_IDLE/ST_FILL/ST_ARMED/ST_HIT and the 2-bit state typedef/width constant.
- One sub-module, sat_counter (params CNT_W; ports clk, rst, inc, clr, count, sat), implements the saturating counter with clear-priority-then-increment rule.
- FSM, shift history and comparator live in seq_detector_prog.

Test Plan:
1. Hold rst=0 mid-run, release → count=0, match=0, state=2'b00, sat=0, pat_reg=101 (a 1,0,1 stream matches without loading).
2. PAT_LEN=3, pattern 101, overlap_en=1, din 1,0,1,0,1 (valid every cycle) → match pulses after bits 3 and 5, count=2; state sequence 00,01,01,11,10,11.
3. Same pattern, overlap_en=0:
   - din 1,0,1,0,1 → one match, count=1.
   - Then din 1,0,1,1,0,1 → count=3 (matches at bits 3 and 6).
4. din_valid gaps: 1,(gap),0,(gap),(gap),1 → single match pulse one cycle after the final accepted bit; state holds through gaps.
5. Feed 1,1, then pat_load with pattern 110 and din_valid=1 same cycle → state=IDLE, that bit dropped. Then 1,1,0 → match, count unchanged before the match.
6. CNT_W=2, five matches → count=3, sat=1, no wrap. Then count_clr concurrent with a match → count=1, sat=0.
